// File: rtl/uart_freq_loader.sv
// uart_freq_loader: 8N1 UART receiver feeding a packet parser that loads
// checksummed frequency words into per-channel output registers.
module uart_freq_loader #(
    parameter int CLKS_PER_BIT = 521,
    parameter int NUM_CH       = 4,
    parameter int WORD_W       = 32,
    parameter int TIMEOUT_BITS = 20,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    output logic [NUM_CH*WORD_W-1:0] freq_out,
    output logic                     done,
    output logic [CH_W-1:0]          done_ch,
    output logic                     err,
    output logic [1:0]               err_code
);
    localparam int NB     = WORD_W / 8;
    localparam int CW     = $clog2(CLKS_PER_BIT);
    localparam int BCW    = (NB > 1) ? $clog2(NB) : 1;
    localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW     = $clog2(TO_CYC);

    localparam logic [CW-1:0]  HALF    = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0]  LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]  TO_LAST = TW'(TO_CYC - 1);
    localparam logic [BCW-1:0] B_LAST  = BCW'(NB - 1);
    localparam logic [4:0]     NCH     = 5'(NUM_CH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} rx_state_t;
    typedef enum logic [1:0] {P_HDR, P_DATA, P_CHK} p_state_t;

    logic            rx_m, rx_s;
    rx_state_t       rstate;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            byte_stb, frame_err;

    p_state_t        pstate;
    logic [3:0]      ch;
    logic [BCW-1:0]  bcnt;
    logic [WORD_W-1:0] shadow;
    logic [7:0]      chk;
    logic [TW-1:0]   tmo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate    <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
            unique case (rstate)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) rstate <= START;
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        rstate  <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) rstate <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            byte_stb <= 1'b1;
                            rstate   <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            rstate    <= WAIT_HI;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HI: if (rx_s) rstate <= IDLE;
                default: rstate <= IDLE;
            endcase
        end
    end

    // Data bytes land in shadow; freq_out only changes on a checksum match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pstate   <= P_HDR;
            ch       <= '0;
            bcnt     <= '0;
            shadow   <= '0;
            chk      <= '0;
            tmo      <= '0;
            freq_out <= '0;
            done     <= 1'b0;
            done_ch  <= '0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            tmo  <= (pstate == P_HDR || byte_stb) ? '0 : tmo + 1'b1;
            if (frame_err) begin
                err      <= 1'b1;
                err_code <= 2'b01;
                pstate   <= P_HDR;
                shadow   <= '0;
            end else if (byte_stb) begin
                unique case (pstate)
                    P_HDR: begin
                        if (shreg[7:4] == 4'hA && {1'b0, shreg[3:0]} < NCH) begin
                            ch     <= shreg[3:0];
                            chk    <= shreg;
                            shadow <= '0;
                            bcnt   <= '0;
                            pstate <= P_DATA;
                        end else begin
                            err      <= 1'b1;
                            err_code <= 2'b10;
                        end
                    end
                    P_DATA: begin
                        shadow[bcnt*8 +: 8] <= shreg;
                        chk <= chk ^ shreg;
                        if (bcnt == B_LAST) pstate <= P_CHK;
                        else bcnt <= bcnt + 1'b1;
                    end
                    P_CHK: begin
                        if (shreg == chk) begin
                            freq_out[ch*WORD_W +: WORD_W] <= shadow;
                            done    <= 1'b1;
                            done_ch <= ch[CH_W-1:0];
                        end else begin
                            err      <= 1'b1;
                            err_code <= 2'b11;
                        end
                        pstate <= P_HDR;
                        shadow <= '0;
                    end
                    default: pstate <= P_HDR;
                endcase
            end else if (pstate != P_HDR && tmo == TO_LAST) begin
                err      <= 1'b1;
                err_code <= 2'b00;
                pstate   <= P_HDR;
                shadow   <= '0;
            end
        end
    end
endmodule

// File: doc/uart_freq_loader.md
UART_FREQ_LOADER -- requirements
Module: uart_freq_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 521, meaning clk cycles per UART bit (115200 baud); SHALL be >= 8.
REQ-002 Parameter NUM_CH, default 4, meaning number of frequency channels (1..16).
REQ-003 Parameter WORD_W, default 32, meaning frequency word width; SHALL be a multiple of 8 (8..64).
REQ-004 Parameter TIMEOUT_BITS, default 20, meaning max idle bit periods between bytes inside a packet.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 rx  input  1  asynchronous UART line, idle high, 8N1, LSB first.
REQ-008 freq_out  output  NUM_CH*WORD_W  channel words; channel k at bits [k*WORD_W +: WORD_W].
REQ-009 done  output  1  one-cycle pulse on successful channel update.
REQ-010 done_ch  output  max(1,clog2(NUM_CH))  channel index of last successful update.
REQ-011 err  output  1  one-cycle pulse on any discarded byte/packet.
REQ-012 err_code  output  2  cause of last err: 00 timeout, 01 framing, 10 bad header, 11 checksum.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-014 Byte FSM states IDLE, START, DATA, STOP, WAIT_HI; IDLE->START on synchronized rx low.
REQ-015 START: at count (CLKS_PER_BIT-1)/2 rx low -> DATA with count cleared; rx high -> IDLE, no err (glitch).
REQ-016 DATA: sample every CLKS_PER_BIT cycles, 8 bits LSB first, then STOP.
REQ-017 STOP: sample after CLKS_PER_BIT; high -> byte strobe, IDLE; low -> framing err (01), byte dropped, WAIT_HI.
REQ-018 WAIT_HI: remain until synchronized rx high, then IDLE.
REQ-019 Packet = header, WORD_W/8 data bytes (LS byte first), checksum byte; parser states P_HDR, P_DATA, P_CHK.
REQ-020 Header: bits[7:4] SHALL equal 0xA and bits[3:0] < NUM_CH, else err 10, stay P_HDR.
REQ-021 Data bytes SHALL load a shadow register, never freq_out directly.
REQ-022 Checksum SHALL equal XOR of header and all data bytes; mismatch -> err 11, shadow discarded, P_HDR.
REQ-023 Checksum match -> selected channel word replaced whole, done pulse, done_ch updated, same cycle, one cycle after checksum stop-bit sample.
REQ-024 Other channels SHALL never change on an update.
REQ-025 Timeout: in P_DATA/P_CHK, TIMEOUT_BITS*CLKS_PER_BIT cycles with no byte strobe since last byte -> err 00, P_HDR.
REQ-026 Framing error in any parser state SHALL return parser to P_HDR.
REQ-027 err and done SHALL never both assert in the same cycle; err_code and done_ch hold between events.
REQ-028 Counter widths SHALL be sized from parameters; no wrap before terminal count.

Reset
REQ-029 rst high: sync flops and line state to 1, FSMs to IDLE/P_HDR, all counters and shadow to 0.
REQ-030 rst high: freq_out all 0, done 0, done_ch 0, err 0, err_code 00.
REQ-031 rst asserted mid-packet SHALL discard the packet; no done or err on release.

Verification (CLKS_PER_BIT=16, NUM_CH=4, WORD_W=32, TIMEOUT_BITS=20)
REQ-032 Bytes A1 78 56 34 12 A9 -> channel 1 = 0x12345678, done pulse once, done_ch=1, others 0.
REQ-033 Bytes A1 78 56 34 12 A8 -> err pulse, err_code 11, channel 1 unchanged.
REQ-034 Header A5, then A2 01 00 00 00 A3 -> err 10 for A5; channel 2 = 0x00000001.
REQ-035 Byte with stop bit low mid-packet -> err 01; next valid packet accepted.
REQ-036 A0 11 22 then 20 idle bit periods -> err 00; channel 0 unchanged; next valid packet accepted.
REQ-037 rx low pulse of 5 cycles -> no byte, no err; rst mid-packet -> all outputs 0, no pulses.
